// File: rtl/lcd_spi_fill_ctrl.sv
// SPI display controller: mode-0 byte serializer, automatic panel init after reset,
// and solid-colour window fills on request.
module lcd_spi_fill_ctrl #(
    parameter int CLK_DIV   = 10,
    parameter int PIX_BYTES = 2,
    parameter int PIX_COUNT = 57600,
    parameter int CNT_W     = 17,
    parameter int SLP_WAIT  = 12000000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [8*PIX_BYTES-1:0] color,
    output logic                   busy,
    output logic                   init_done,
    output logic                   done,
    output logic                   scl,
    output logic                   sda,
    output logic                   cs,
    output logic                   dc
);
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int WAIT_W = $clog2(SLP_WAIT + 1);
    localparam int CW     = 8 * PIX_BYTES;

    typedef enum logic [2:0] {
        INIT_A, INIT_SLP, INIT_B, INIT_END, IDLE, FILL_CMD, FILL_DATA, FILL_END
    } state_t;

    state_t              state, state_nxt;
    logic [DIV_W-1:0]    div_cnt;
    logic [2:0]          bit_cnt;
    logic [1:0]          byte_idx;
    logic [CNT_W-1:0]    pix_cnt;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [7:0]          shreg;
    logic [CW-1:0]       color_reg;
    logic                hold;

    logic       div_end, byte_end, hold_end, wait_end;
    logic       launch, last_byte, next_dc;
    logic [7:0] launch_byte, next_byte;
    logic [1:0] data_idx_nxt;

    function automatic logic [7:0] pix_byte(input logic [CW-1:0] c, input logic [1:0] idx);
        return 8'(c >> (8 * (PIX_BYTES - 1 - int'(idx))));
    endfunction

    assign div_end      = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign byte_end     = !cs && !hold && scl && div_end && (bit_cnt == 3'd7);
    assign hold_end     = !cs && hold && div_end;
    assign wait_end     = (state == INIT_SLP) && (wait_cnt == WAIT_W'(SLP_WAIT - 1));
    assign data_idx_nxt = (byte_idx == 2'(PIX_BYTES - 1)) ? 2'd0 : byte_idx + 2'd1;

    assign sda       = shreg[7];
    assign busy      = (state != IDLE);
    assign done      = (state == FILL_END);
    assign init_done = (state == IDLE) || (state == FILL_CMD) ||
                       (state == FILL_DATA) || (state == FILL_END);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= INIT_A;
        else       state <= state_nxt;
    end

    // Frame sequencing: which byte opens a frame, which byte follows, which byte is last.
    always_comb begin
        state_nxt   = state;
        launch      = 1'b0;
        launch_byte = 8'h00;
        last_byte   = 1'b1;
        next_byte   = 8'h00;
        next_dc     = 1'b1;
        case (state)
            INIT_A: begin
                if (cs) begin
                    launch      = 1'b1;
                    launch_byte = 8'h11;
                end
                if (hold_end) state_nxt = INIT_SLP;
            end
            INIT_SLP: begin
                if (wait_end) begin
                    launch      = 1'b1;
                    launch_byte = 8'h29;
                    state_nxt   = INIT_B;
                end
            end
            INIT_B: begin
                last_byte = (byte_idx == 2'd2);
                next_byte = (byte_idx == 2'd0) ? 8'h3A : 8'h55;
                next_dc   = (byte_idx != 2'd0);
                if (hold_end) state_nxt = INIT_END;
            end
            INIT_END: state_nxt = IDLE;
            IDLE: begin
                if (start) begin
                    launch      = 1'b1;
                    launch_byte = 8'h2C;
                    state_nxt   = FILL_CMD;
                end
            end
            FILL_CMD: begin
                last_byte = 1'b0;
                next_byte = pix_byte(color_reg, 2'd0);
                if (byte_end) state_nxt = FILL_DATA;
            end
            FILL_DATA: begin
                last_byte = (pix_cnt == CNT_W'(PIX_COUNT - 1)) &&
                            (byte_idx == 2'(PIX_BYTES - 1));
                next_byte = pix_byte(color_reg, data_idx_nxt);
                if (hold_end) state_nxt = FILL_END;
            end
            FILL_END: state_nxt = IDLE;
            default:  state_nxt = INIT_A;
        endcase
    end

    // Serializer: cells of CLK_DIV low + CLK_DIV high, then CLK_DIV of cs hold after the last byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs        <= 1'b1;
            scl       <= 1'b0;
            dc        <= 1'b0;
            shreg     <= 8'h00;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            byte_idx  <= '0;
            pix_cnt   <= '0;
            wait_cnt  <= '0;
            color_reg <= '0;
            hold      <= 1'b0;
        end else begin
            wait_cnt <= (state == INIT_SLP) ? wait_cnt + 1'b1 : '0;
            if (launch) begin
                cs       <= 1'b0;
                scl      <= 1'b0;
                dc       <= 1'b0;
                shreg    <= launch_byte;
                div_cnt  <= '0;
                bit_cnt  <= '0;
                byte_idx <= '0;
                pix_cnt  <= '0;
                hold     <= 1'b0;
                if (state == IDLE) color_reg <= color;
            end else if (!cs) begin
                div_cnt <= div_end ? '0 : div_cnt + 1'b1;
                if (hold) begin
                    if (div_end) begin
                        cs   <= 1'b1;
                        hold <= 1'b0;
                    end
                end else if (div_end) begin
                    scl <= !scl;
                    if (scl) begin
                        if (bit_cnt != 3'd7) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            shreg   <= {shreg[6:0], 1'b0};
                        end else begin
                            bit_cnt <= 3'd0;
                            if (last_byte) begin
                                hold <= 1'b1;
                            end else begin
                                shreg <= next_byte;
                                dc    <= next_dc;
                                if (state == FILL_DATA) begin
                                    byte_idx <= data_idx_nxt;
                                    if (byte_idx == 2'(PIX_BYTES - 1)) pix_cnt <= pix_cnt + 1'b1;
                                end else if (state == INIT_B) begin
                                    byte_idx <= byte_idx + 2'd1;
                                end
                            end
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_lcd_spi_fill_ctrl.sv
// Directed bench for lcd_spi_fill_ctrl: decodes the SPI pins of two instances and
// checks init, fills, start filtering, reset abort and back-to-back fills.
module tb_lcd_spi_fill_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start0, start1;
    logic [15:0] color0;
    logic [23:0] color1;
    logic busy[2], init_done[2], done[2], scl[2], sda[2], cs[2], dc[2];

    lcd_spi_fill_ctrl #(.CLK_DIV(2), .PIX_BYTES(2), .PIX_COUNT(4), .CNT_W(3), .SLP_WAIT(20)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .color(color0), .busy(busy[0]),
        .init_done(init_done[0]), .done(done[0]), .scl(scl[0]), .sda(sda[0]), .cs(cs[0]), .dc(dc[0]));

    lcd_spi_fill_ctrl #(.CLK_DIV(2), .PIX_BYTES(3), .PIX_COUNT(2), .CNT_W(2), .SLP_WAIT(20)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .color(color1), .busy(busy[1]),
        .init_done(init_done[1]), .done(done[1]), .scl(scl[1]), .sda(sda[1]), .cs(cs[1]), .dc(dc[1]));

    int checks = 0;
    int failures = 0;

    // SPI decoder state, one slot per instance.
    int         nbits[2]    = '{0, 0};
    logic [7:0] shb[2];
    logic       dcs[2];
    logic [8:0] blog[2][256];
    int         bcnt[2]     = '{0, 0};
    int         low_log[2][64];
    int         high_log[2][64];
    int         low_n[2]    = '{0, 0};
    int         high_n[2]   = '{0, 0};
    int         low_run[2]  = '{0, 0};
    int         high_run[2] = '{0, 0};
    int         done_cyc[2] = '{0, 0};
    int         done_n[2]   = '{0, 0};
    int         viol[2]     = '{0, 0};
    logic       pscl[2]     = '{1'b0, 1'b0};
    logic       psda[2]     = '{1'b0, 1'b0};
    logic       pcs[2]      = '{1'b1, 1'b1};
    logic       pdone[2]    = '{1'b0, 1'b0};

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                nbits[i] = 0;
            end else begin
                if (!cs[i] && scl[i] && !pscl[i]) begin
                    if (nbits[i] == 0) dcs[i] = dc[i];
                    else if (dc[i] !== dcs[i]) viol[i]++;
                    shb[i] = {shb[i][6:0], sda[i]};
                    nbits[i]++;
                    if (nbits[i] == 8) begin
                        if (bcnt[i] < 256) blog[i][bcnt[i]] = {dcs[i], shb[i]};
                        bcnt[i]++;
                        nbits[i] = 0;
                    end
                end
                if (scl[i] && (sda[i] !== psda[i])) viol[i]++;
            end
            if (cs[i]) begin
                if (!pcs[i]) begin
                    if (low_n[i] < 64) low_log[i][low_n[i]] = low_run[i];
                    low_n[i]++;
                    low_run[i] = 0;
                end
                high_run[i]++;
            end else begin
                if (pcs[i]) begin
                    if (high_n[i] < 64) high_log[i][high_n[i]] = high_run[i];
                    high_n[i]++;
                    high_run[i] = 0;
                end
                low_run[i]++;
            end
            if (done[i]) begin
                done_cyc[i]++;
                if (!pdone[i]) done_n[i]++;
            end
            pscl[i]  = scl[i];
            psda[i]  = sda[i];
            pcs[i]   = cs[i];
            pdone[i] = done[i];
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ge2(input string tag, input int obs);
        checks++;
        assert (obs >= 2) else begin
            failures++;
            $error("FAIL %s observed=%0d expected>=2", tag, obs);
        end
    endtask

    logic [8:0] exp_init[4] = '{9'h011, 9'h029, 9'h03A, 9'h155};
    logic [8:0] exp_fill[9] = '{9'h02C, 9'h1F8, 9'h100, 9'h1F8, 9'h100, 9'h1F8, 9'h100, 9'h1F8, 9'h100};
    logic [8:0] exp_p3[7]   = '{9'h02C, 9'h112, 9'h134, 9'h156, 9'h112, 9'h134, 9'h156};

    initial begin
        int b, l, h, dn, dcy, n;
        reset = 1'b1; start0 = 1'b0; start1 = 1'b0; color0 = '0; color1 = '0;
        repeat (3) step();
        chk("rst_cs", cs[0], 1);
        chk("rst_scl", scl[0], 0);
        chk("rst_sda", sda[0], 0);
        chk("rst_dc", dc[0], 0);
        chk("rst_busy", busy[0], 1);
        chk("rst_init_done", init_done[0], 0);
        chk("rst_done", done[0], 0);

        // Init with start pulses that must be ignored.
        reset = 1'b0;
        repeat (10) step();
        start0 = 1'b1; repeat (3) step(); start0 = 1'b0;
        repeat (50) step();
        start0 = 1'b1; repeat (3) step(); start0 = 1'b0;
        n = 0;
        while (!init_done[0] && n < 400) begin step(); n++; end
        chk("init_done", init_done[0], 1);
        chk("init_busy", busy[0], 0);
        for (int k = 0; k < 4; k++) chk($sformatf("init_byte%0d", k), blog[0][k], exp_init[k]);
        chk("init_a_cs_low", low_log[0][0], 34);
        chk("slp_wait_gap", high_log[0][1], 20);
        chk("init_b_cs_low", low_log[0][1], 98);
        repeat (20) step();
        chk("init_no_fill", bcnt[0], 4);
        chk("init_no_done", done_n[0], 0);

        // Fill 0xF800, with a colour change and start pulse mid-fill.
        b = bcnt[0]; l = low_n[0];
        color0 = 16'hF800; start0 = 1'b1;
        step();
        chk("start_cs_fall", cs[0], 0);
        chk("start_busy", busy[0], 1);
        start0 = 1'b0;
        repeat (100) step();
        color0 = 16'h07E0; start0 = 1'b1;
        step();
        start0 = 1'b0;
        n = 0;
        while (!done[0] && n < 400) begin step(); n++; end
        chk("fill_done", done[0], 1);
        chk("done_cs_high", cs[0], 1);
        step();
        chk("done_width", done[0], 0);
        chk("fill_idle_busy", busy[0], 0);
        for (int k = 0; k < 9; k++) chk($sformatf("fill_byte%0d", k), blog[0][b+k], exp_fill[k]);
        chk("fill_cs_low", low_log[0][l], 290);
        repeat (40) step();
        chk("one_done", done_n[0], 1);
        chk("no_extra_fill", bcnt[0], b + 9);

        // Reset in the middle of a pixel byte (0x34, sda and scl both high).
        color0 = 16'h1234; start0 = 1'b1;
        step();
        start0 = 1'b0;
        repeat (74) step();
        chk("pre_rst_scl", scl[0], 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_cs", cs[0], 1);
        chk("mid_rst_scl", scl[0], 0);
        chk("mid_rst_sda", sda[0], 0);
        chk("mid_rst_dc", dc[0], 0);
        chk("mid_rst_busy", busy[0], 1);
        chk("mid_rst_init_done", init_done[0], 0);
        repeat (3) step();
        b = bcnt[0]; l = low_n[0]; h = high_n[0];
        reset = 1'b0;
        step();
        chk("reinit_not_done", init_done[0], 0);
        n = 0;
        while (!init_done[0] && n < 400) begin step(); n++; end
        chk("reinit_done", init_done[0], 1);
        for (int k = 0; k < 4; k++) chk($sformatf("reinit_byte%0d", k), blog[0][b+k], exp_init[k]);
        chk("reinit_a_cs_low", low_log[0][l], 34);
        chk("reinit_b_cs_low", low_log[0][l+1], 98);
        chk("reinit_slp_gap", high_log[0][h+1], 20);

        // Start held high: three back-to-back fills.
        b = bcnt[0]; l = low_n[0]; h = high_n[0]; dn = done_n[0]; dcy = done_cyc[0];
        color0 = 16'hABCD; start0 = 1'b1;
        n = 0;
        while (done_n[0] < dn + 3 && n < 1200) begin step(); n++; end
        chk("held_three_done", done_n[0], dn + 3);
        start0 = 1'b0;
        repeat (5) step();
        chk("held_frames", low_n[0], l + 3);
        chk("held_done_cycles", done_cyc[0], dcy + 3);
        for (int k = 0; k < 3; k++) chk($sformatf("held_cs_low%0d", k), low_log[0][l+k], 290);
        chk_ge2("held_gap1", high_log[0][h+1]);
        chk_ge2("held_gap2", high_log[0][h+2]);
        chk("held_cmd", blog[0][b], 9'h02C);
        chk("held_byte_hi", blog[0][b+1], 9'h1AB);
        chk("held_byte_lo", blog[0][b+2], 9'h1CD);

        // Three-byte pixels on the second instance.
        b = bcnt[1]; l = low_n[1];
        color1 = 24'h123456; start1 = 1'b1;
        step();
        start1 = 1'b0;
        n = 0;
        while (!done[1] && n < 400) begin step(); n++; end
        chk("p3_done", done[1], 1);
        step();
        for (int k = 0; k < 7; k++) chk($sformatf("p3_byte%0d", k), blog[1][b+k], exp_p3[k]);
        chk("p3_cs_low", low_log[1][l], 226);
        chk("sda_stable_0", viol[0], 0);
        chk("sda_stable_1", viol[1], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
